cordic_arbiter: RTL and testbench

Shares a single `cordic_engine` between two requesters, A and B. Requests are granted round-robin and issued through a one-entry issue register that honours the engine's `pop` back-pressure. Because the engine returns results in issue order, a tag FIFO records the owner of each issued operation, and every `eng_valid_out` result is routed back to that owner. The block sits between the two phase-generating clients and the engine instance.

---
 rtl/cordic_arbiter.sv | 116 +++++++++++
 tb/tb_cordic_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one cordic_engine between requesters A and B.
// A tag FIFO tracks the owner of each in-order engine result.
module cordic_arbiter #(
  parameter int IO_BW = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [IO_BW-1:0]           a_phase,
  input  logic [2:0]                 a_mode,
  output logic                       a_rvalid,
  output logic [IO_BW-1:0]           a_result,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [IO_BW-1:0]           b_phase,
  input  logic [2:0]                 b_mode,
  output logic                       b_rvalid,
  output logic [IO_BW-1:0]           b_result,
  output logic                       eng_valid_in,
  output logic [IO_BW-1:0]           eng_phase,
  output logic [2:0]                 eng_mode,
  input  logic                       eng_pop,
  input  logic                       eng_valid_out,
  input  logic [IO_BW-1:0]           eng_result,
  output logic [$clog2(DEPTH):0]     outstanding,
  output logic                       err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic             last;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [DEPTH-1:0] tag_q;

  logic consume;
  logic can_accept;
  logic gnt_a;
  logic gnt_b;
  logic accept;
  logic ret;
  logic head;

  assign consume    = eng_valid_in && !eng_pop;
  assign can_accept = (!eng_valid_in || consume) && (outstanding < FULL);

  // last=1 means B won last time, so A has priority on a tie
  assign gnt_a = a_valid && (!b_valid || last);
  assign gnt_b = b_valid && (!a_valid || !last);

  assign a_ready = gnt_a && can_accept;
  assign b_ready = gnt_b && can_accept;
  assign accept  = a_ready || b_ready;

  // results with no recorded owner are dropped
  assign ret  = eng_valid_out && (outstanding != '0);
  assign head = tag_q[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last         <= 1'b1;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      tag_q        <= '0;
      eng_valid_in <= 1'b0;
      eng_phase    <= '0;
      eng_mode     <= '0;
      a_rvalid     <= 1'b0;
      b_rvalid     <= 1'b0;
      a_result     <= '0;
      b_result     <= '0;
      outstanding  <= '0;
      err          <= 1'b0;
    end else begin
      if (accept) begin
        eng_valid_in  <= 1'b1;
        eng_phase     <= b_ready ? b_phase : a_phase;
        eng_mode      <= b_ready ? b_mode : a_mode;
        tag_q[wr_ptr] <= b_ready;
        wr_ptr        <= wr_ptr + PW'(1);
        last          <= b_ready;
      end else if (consume) begin
        eng_valid_in <= 1'b0;
      end

      if (ret) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      a_rvalid <= ret && !head;
      b_rvalid <= ret && head;

      if (ret && !head) begin
        a_result <= eng_result;
      end
      if (ret && head) begin
        b_result <= eng_result;
      end

      if (eng_valid_out && outstanding == '0) begin
        err <= 1'b1;
      end

      unique case ({accept, ret})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter: vector table plus
// back-pressure, full-FIFO and error/reset sequences.
module tb_cordic_arbiter;

  localparam logic [31:0] PA = 32'h1000_0000;
  localparam logic [31:0] PB = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, a_rvalid;
  logic [31:0] a_phase, a_result;
  logic [2:0]  a_mode;
  logic        b_valid, b_ready, b_rvalid;
  logic [31:0] b_phase, b_result;
  logic [2:0]  b_mode;
  logic        eng_valid_in, eng_pop, eng_valid_out;
  logic [31:0] eng_phase, eng_result;
  logic [2:0]  eng_mode;
  logic [3:0]  outstanding;
  logic        err;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  cordic_arbiter #(.IO_BW(32), .DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_phase(a_phase),
    .a_mode(a_mode), .a_rvalid(a_rvalid), .a_result(a_result),
    .b_valid(b_valid), .b_ready(b_ready), .b_phase(b_phase),
    .b_mode(b_mode), .b_rvalid(b_rvalid), .b_result(b_result),
    .eng_valid_in(eng_valid_in), .eng_phase(eng_phase),
    .eng_mode(eng_mode), .eng_pop(eng_pop),
    .eng_valid_out(eng_valid_out), .eng_result(eng_result),
    .outstanding(outstanding), .err(err)
  );

  typedef struct {
    logic        av, bv, pop, evo;
    logic [31:0] res;
    logic        ea, eb, evi;
    logic [31:0] ph;
    logic [2:0]  md;
    logic [3:0]  out;
    logic        arv, brv;
    logic [31:0] ares, bres;
  } vec_t;

  vec_t v [16];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic av, logic bv, logic pop, logic evo,
                       logic [31:0] res);
    a_valid       = av;
    b_valid       = bv;
    eng_pop       = pop;
    eng_valid_out = evo;
    eng_result    = res;
  endtask

  task automatic do_reset;
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    a_phase = PA; a_mode = 3'd1;
    b_phase = PB; b_mode = 3'd2;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);

    // round-robin burst, in-order returns, then a single A request
    v[0]  = '{1,1,0,0,0,     1,0,1,PA,1,1,0,0,0,0};
    v[1]  = '{1,1,0,0,0,     0,1,1,PB,2,2,0,0,0,0};
    v[2]  = '{1,1,0,0,0,     1,0,1,PA,1,3,0,0,0,0};
    v[3]  = '{1,1,0,0,0,     0,1,1,PB,2,4,0,0,0,0};
    v[4]  = '{1,1,0,0,0,     1,0,1,PA,1,5,0,0,0,0};
    v[5]  = '{1,1,0,0,0,     0,1,1,PB,2,6,0,0,0,0};
    v[6]  = '{0,0,0,1,'h11,  0,0,0,PB,2,5,1,0,'h11,0};
    v[7]  = '{0,0,0,1,'h22,  0,0,0,PB,2,4,0,1,'h11,'h22};
    v[8]  = '{0,0,0,1,'h33,  0,0,0,PB,2,3,1,0,'h33,'h22};
    v[9]  = '{0,0,0,1,'h44,  0,0,0,PB,2,2,0,1,'h33,'h44};
    v[10] = '{0,0,0,1,'h55,  0,0,0,PB,2,1,1,0,'h55,'h44};
    v[11] = '{0,0,0,1,'h66,  0,0,0,PB,2,0,0,1,'h55,'h66};
    v[12] = '{1,0,0,0,0,     1,0,1,PA,1,1,0,0,'h55,'h66};
    v[13] = '{0,0,0,0,0,     0,0,0,PA,1,1,0,0,'h55,'h66};
    v[14] = '{0,0,0,1,'hABC, 0,0,0,PA,1,0,1,0,'hABC,'h66};
    v[15] = '{0,0,0,0,0,     0,0,0,PA,1,0,0,0,'hABC,'h66};

    tick;
    chk("rst_evi", eng_valid_in, 0);
    chk("rst_out", 32'(outstanding), 0);
    chk("rst_phase", eng_phase, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(v[i].av, v[i].bv, v[i].pop, v[i].evo, v[i].res);
      #1;
      chk($sformatf("v%0d_a_ready", i), a_ready, v[i].ea);
      chk($sformatf("v%0d_b_ready", i), b_ready, v[i].eb);
      tick;
      chk($sformatf("v%0d_evi", i), eng_valid_in, v[i].evi);
      chk($sformatf("v%0d_phase", i), eng_phase, v[i].ph);
      chk($sformatf("v%0d_mode", i), 32'(eng_mode), 32'(v[i].md));
      chk($sformatf("v%0d_out", i), 32'(outstanding), 32'(v[i].out));
      chk($sformatf("v%0d_arv", i), a_rvalid, v[i].arv);
      chk($sformatf("v%0d_brv", i), b_rvalid, v[i].brv);
      chk($sformatf("v%0d_ares", i), a_result, v[i].ares);
      chk($sformatf("v%0d_bres", i), b_result, v[i].bres);
    end

    // back-pressure: issue register frozen while pop is high
    do_reset;
    drive(1, 0, 0, 0, 0);
    tick;
    chk("bp_issue", eng_phase, PA);
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 1, 0, 0);
      #1;
      chk($sformatf("bp%0d_a_ready", k), a_ready, 0);
      chk($sformatf("bp%0d_b_ready", k), b_ready, 0);
      tick;
      chk($sformatf("bp%0d_phase", k), eng_phase, PA);
      chk($sformatf("bp%0d_mode", k), 32'(eng_mode), 1);
      chk($sformatf("bp%0d_evi", k), eng_valid_in, 1);
    end
    drive(1, 1, 0, 0, 0);
    #1;
    chk("bp_release_b_ready", b_ready, 1);
    chk("bp_release_a_ready", a_ready, 0);
    tick;
    chk("bp_release_phase", eng_phase, PB);
    chk("bp_release_out", 32'(outstanding), 2);

    // full FIFO
    do_reset;
    for (int k = 0; k < 8; k++) begin
      drive(1, 0, 0, 0, 0);
      #1;
      chk($sformatf("fill%0d_a_ready", k), a_ready, 1);
      tick;
    end
    chk("full_out", 32'(outstanding), 8);
    drive(1, 1, 0, 1, 32'h99);
    #1;
    chk("full_a_ready", a_ready, 0);
    chk("full_b_ready", b_ready, 0);
    tick;
    chk("full_pop_out", 32'(outstanding), 7);
    chk("full_pop_arv", a_rvalid, 1);
    chk("full_pop_ares", a_result, 32'h99);
    drive(1, 1, 0, 0, 0);
    #1;
    chk("resume_b_ready", b_ready, 1);
    chk("resume_a_ready", a_ready, 0);
    tick;
    chk("resume_out", 32'(outstanding), 8);

    // error on empty FIFO, then async reset mid-burst
    do_reset;
    drive(0, 0, 0, 1, 32'hDEAD);
    tick;
    chk("empty_err", err, 1);
    chk("empty_arv", a_rvalid, 0);
    chk("empty_brv", b_rvalid, 0);
    chk("empty_out", 32'(outstanding), 0);
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 0, 0);
      tick;
    end
    drive(0, 0, 0, 1, 32'h77);
    tick;
    chk("pre_rst_out", 32'(outstanding), 3);
    chk("pre_rst_ares", a_result, 32'h77);
    drive(1, 0, 0, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_out", 32'(outstanding), 0);
    chk("arst_err", err, 0);
    chk("arst_evi", eng_valid_in, 0);
    chk("arst_phase", eng_phase, 0);
    chk("arst_mode", 32'(eng_mode), 0);
    chk("arst_ares", a_result, 0);
    chk("arst_arv", a_rvalid, 0);
    chk("arst_a_ready", a_ready, 1);
    tick;
    rst = 1'b0;
    drive(0, 0, 0, 1, 32'h5);
    tick;
    chk("post_rst_err", err, 1);
    chk("post_rst_out", 32'(outstanding), 0);
    drive(0, 0, 0, 0, 0);
    tick;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
